// File: rtl/jtcontra_objbuf.sv
// rtl/jtcontra_objbuf.sv - double-buffered sprite line buffer with clear-behind-beam scan-out
// Renderer writes the back bank while the front bank is scanned and zeroed; banks swap on LHBL fall.
module jtcontra_objbuf #(
   parameter int AW = 9,
   parameter int DW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic [AW-1:0] hdump,
   input  logic          buf_we,
   input  logic [AW-1:0] buf_addr,
   input  logic [DW-1:0] buf_din,
   output logic          ready,
   output logic          swap,
   output logic [DW-1:0] pxl
);

   localparam int DEPTH = 2**(AW+1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic          swap_q, swap_d;
   logic          bank_sel_q, bank_sel_d;
   logic          lhbl_q, lhbl_d;
   logic          clr_pend_q, clr_pend_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [DW-1:0] pxl_pre_q, pxl_pre_d;
   logic [DW-1:0] pxl_q, pxl_d;

   logic          a_we;
   logic [AW:0]   a_addr;
   logic [DW-1:0] a_din;
   logic          b_we;
   logic          b_rd;
   logic [AW:0]   b_addr;
   logic [DW-1:0] ram_q;
   logic [DW-1:0] mem [DEPTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready_d    = ready_q;
      swap_d     = 1'b0;
      bank_sel_d = bank_sel_q;
      lhbl_d     = LHBL;
      clr_pend_d = clr_pend_q;
      rd_addr_d  = rd_addr_q;
      pxl_pre_d  = pxl_pre_q;
      pxl_d      = pxl_q;
      a_we       = 1'b0;
      a_addr     = '0;
      a_din      = '0;
      b_we       = 1'b0;
      b_rd       = 1'b0;
      b_addr     = '0;
      if (state_q == ST_INIT) begin
         // Sweep both banks through port A; renderer and scan-out are locked out meanwhile.
         a_we   = 1'b1;
         a_addr = cnt_q;
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
      end else begin
         a_we   = buf_we && (buf_din[3:0] != 4'd0);
         a_addr = {~bank_sel_q, buf_addr};
         a_din  = buf_din;
         if (lhbl_q && !LHBL) begin
            bank_sel_d = ~bank_sel_q;
            swap_d     = 1'b1;
         end
         if (clr_pend_q) begin
            b_we       = 1'b1;
            b_addr     = {bank_sel_q, rd_addr_q};
            pxl_pre_d  = ram_q;
            clr_pend_d = 1'b0;
         end
         if (pxl_cen) begin
            pxl_d = pxl_pre_q;
            if (LHBL) begin
               b_rd       = 1'b1;
               b_addr     = {bank_sel_q, hdump};
               rd_addr_d  = hdump;
               clr_pend_d = 1'b1;
            end else begin
               pxl_pre_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         swap_q     <= 1'b0;
         bank_sel_q <= 1'b0;
         lhbl_q     <= 1'b0;
         clr_pend_q <= 1'b0;
         rd_addr_q  <= '0;
         pxl_pre_q  <= '0;
         pxl_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         swap_q     <= swap_d;
         bank_sel_q <= bank_sel_d;
         lhbl_q     <= lhbl_d;
         clr_pend_q <= clr_pend_d;
         rd_addr_q  <= rd_addr_d;
         pxl_pre_q  <= pxl_pre_d;
         pxl_q      <= pxl_d;
      end
   end

   // Port A and port B always target opposite banks, so the two writes never collide.
   always_ff @(posedge clk) begin
      if (a_we) mem[a_addr] <= a_din;
      if (b_we) mem[b_addr] <= '0;
      if (b_rd) ram_q <= mem[b_addr];
   end

   assign ready = ready_q;
   assign swap  = swap_q;
   assign pxl   = pxl_q;

endmodule

// File: doc/jtcontra_objbuf.md
# jtcontra_objbuf

Double-buffered object (sprite) line buffer for the Contra video path. The sprite renderer writes one line of object pixels into the back bank while the front bank is scanned out pixel by pixel and cleared behind the beam. Output `pxl` is the 7-bit object colour request consumed by the colour mixer as its `gfx2_pxl` input; bit 4 of that value is the mixer's object-priority flag. Banks swap at the start of every horizontal blank.

## Interface
Parameters:
- AW, 9, line address width; each bank holds 2^AW entries
- DW, 7, pixel width: {palette bits, 4-bit colour}; colour 0 is transparent

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pxl_cen  in  1  pixel clock enable; at least 3 clk cycles between consecutive pulses
- LHBL  in  1  horizontal blank, active low
- hdump  in  AW  scan-out horizontal position
- buf_we  in  1  renderer write strobe, one clk per pixel
- buf_addr  in  AW  renderer x position
- buf_din  in  DW  renderer pixel
- ready  out  1  high once the reset clear sweep has finished
- swap  out  1  one-clk pulse when the banks swap; the renderer starts its next line on this pulse
- pxl  out  DW  object pixel for the colour mixer

## Operation
- Storage is two banks of 2^AW x DW synchronous RAM. The addressed bank is `{bank_sel, addr}`.
- The write bank is `~bank_sel` and the read bank is `bank_sel`.
- FSM states:
  - INIT, entered on reset. A counter sweeps all 2^(AW+1) addresses, writing 0 to one address per clk.
  - On the terminal count the FSM moves to RUN and `ready` rises.
  - In INIT, `buf_we` is ignored, `pxl` = 0, and no `swap` is generated.
- Write path (RUN only): when `buf_we` is high and `buf_din[3:0]` != 0, write `buf_din` to the write bank at `buf_addr`.
  - If `buf_din[3:0]` == 0 the write is dropped, so underlying pixels survive.
  - A later write to the same address overwrites an earlier one; the renderer supplies draw order.
- Read path (RUN only):
  - On a clk with `pxl_cen` high and LHBL high, latch `rd_addr <= hdump` and set `clr_pend`.
  - On the next clk, capture the RAM output into `pxl_pre` and write 0 to the read bank at `rd_addr`; this clears the location behind the beam. `clr_pend` then drops.
  - On the next `pxl_cen`, `pxl <= pxl_pre`.
  - While LHBL is low, no read is issued, no clear is performed, and `pxl_pre` is loaded with 0.
- Swap:
  - Detect the LHBL falling edge, using a registered LHBL sampled every clk.
  - On that edge, `bank_sel` toggles and `swap` pulses for exactly one clk.
- Port arbitration: writes use port A (write bank); read and clear use port B (read bank). The ports never address the same bank, so there are no collisions.

## Timing
- Reset values: `ready` = 0, `swap` = 0, `pxl` = 0, `bank_sel` = 0, FSM = INIT, `clr_pend` = 0, `pxl_pre` = 0.
- `ready` rises exactly 2^(AW+1) clk after rst deasserts; with AW = 9 that is 1024 clk.
- Read latency: the value at `hdump` sampled on pxl_cen k appears on `pxl` at pxl_cen k+1, a one-pixel delay. The mixer's blanking delay accounts for this.
- `swap` is asserted on the clk after the clk where LHBL is first sampled low.
- Writes issued on the same clk as the bank toggle land in the pre-toggle write bank.
- A write issued one clk later lands in the new write bank.
- If rst asserts mid-line, the FSM returns to INIT and both banks are fully re-cleared. Partially rendered or partially cleared data must never reach `pxl`.
- A `pxl_cen` arriving while `clr_pend` is still set violates the spacing requirement and is not supported.

## Test plan
- Reset and init: hold rst for 4 clk, then release → `ready` stays 0 for 1024 clk then goes 1. `pxl` stays 0 throughout. A `buf_we` during INIT does not change any RAM location.
- Write, swap and read:
  - Write 0x35 at x = 10 and 0x12 at x = 11, then drop LHBL.
  - Expect `swap` for 1 clk.
  - Scan hdump = 10, 11, 12 → `pxl` shows 0x35, 0x12, 0x00 on the following pxl_cen each.
- Transparency:
  - Write 0x27 at x = 20, then 0x30 at x = 20 (colour 0).
  - Expect 0x27 read back, because the transparent write is dropped.
  - Then write 0x41 at x = 20 → 0x41 is read back, because later writes overwrite.
- Clear behind beam: after the line above is displayed, swap twice with no writes → rescanning x = 10 yields 0x00.
- Blanking: with LHBL low, pulse `pxl_cen` with hdump = 10 holding a stored 0x35 → `pxl` = 0. The location is not cleared; 0x35 is still read back on the next active pixel at x = 10.
- Mid-line reset: assert rst while writing a line → `ready` falls, the 1024-clk sweep repeats, and every address reads 0 afterwards.
